// File: rtl/cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cmd_sequencer
// Description : Program controller for the executor. Fetches four-word
//               instructions from program ROM, presents them as
//               cmd_flags/cmd_args, runs the exe_flag/ready_flag handshake
//               and applies relative jumps. Stops cleanly on a HALT word and
//               with a fault on a bad opcode, a bad jump target or an
//               executor timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_sequencer #(
  parameter int address_size = 32,
  parameter int word_size    = 32,
  parameter int pc_width     = 8,
  parameter int timeout      = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [address_size-1:0]   rom_addr,
  input  logic [word_size-1:0]      rom_data,
  output logic [5:0]                cmd_flags,
  output logic [3*word_size-1:0]    cmd_args,
  output logic                      exe_flag,
  input  logic                      ready_flag,
  input  logic                      jmp_flag,
  input  logic [address_size-1:0]   new_exe_addr_offset,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [pc_width-1:0]       pc,
  output logic [15:0]               retired
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam int                  c_wcnt_w    = $clog2(timeout + 1);
  localparam logic [c_wcnt_w-1:0] c_wcnt_last = c_wcnt_w'(timeout - 1);
  localparam logic [pc_width-1:0] c_pc_max    = '1;
  // fcnt value used for the single idle cycle between ready_flag and the
  // next fetch; incrementing it wraps to 0 and starts the real fetch.
  localparam logic [2:0]          c_release   = 3'd7;

  state_t                    state_q, state_d;
  logic [2:0]                fcnt_q, fcnt_d;
  logic [c_wcnt_w-1:0]       wcnt_q, wcnt_d;
  logic [pc_width-1:0]       pc_q, pc_d;
  logic [15:0]               retired_q, retired_d;
  logic                      exe_q, exe_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;
  logic [5:0]                cmd_flags_q, cmd_flags_d;
  logic [3*word_size-1:0]    cmd_args_q, cmd_args_d;
  logic [address_size-1:0]   rom_addr_q, rom_addr_d;
  logic [5:0]                flags_buf_q, flags_buf_d;
  logic [word_size-1:0]      w1_q, w1_d;
  logic [word_size-1:0]      w2_q, w2_d;

  // Jump target computed one bit wider than the offset so that negative
  // results and overshoot past the last instruction are both visible.
  logic [address_size:0]     w_jump_target;
  logic                      w_jump_bad;
  logic [15:0]               w_retired_inc;

  assign w_jump_target = {{(address_size + 1 - pc_width){1'b0}}, pc_q}
                       + {new_exe_addr_offset[address_size-1], new_exe_addr_offset};
  assign w_jump_bad    = (w_jump_target[address_size:pc_width] != '0);
  assign w_retired_inc = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    wcnt_d      = wcnt_q;
    pc_d        = pc_q;
    retired_d   = retired_q;
    exe_d       = exe_q;
    done_d      = done_q;
    error_d     = error_q;
    cmd_flags_d = cmd_flags_q;
    cmd_args_d  = cmd_args_q;
    flags_buf_d = flags_buf_q;
    w1_d        = w1_q;
    w2_d        = w2_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d   = S_FETCH;
          fcnt_d    = 3'd0;
          pc_d      = '0;
          retired_d = 16'd0;
          done_d    = 1'b0;
          error_d   = 1'b0;
        end
      end

      S_FETCH: begin
        fcnt_d = fcnt_q + 3'd1;
        // ROM data lags the address by one cycle: word k arrives while
        // fcnt == k+1.
        case (fcnt_q)
          3'd1:    flags_buf_d = rom_data[5:0];
          3'd2:    w1_d        = rom_data;
          3'd3:    w2_d        = rom_data;
          default: ;
        endcase
        if (fcnt_q == 3'd4) begin
          fcnt_d = 3'd0;
          if (flags_buf_q == 6'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if ((flags_buf_q & (flags_buf_q - 6'd1)) != 6'd0) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            state_d     = S_EXEC;
            exe_d       = 1'b1;
            wcnt_d      = '0;
            cmd_flags_d = flags_buf_q;
            cmd_args_d  = {rom_data, w2_q, w1_q};
          end
        end
      end

      S_EXEC: begin
        if (ready_flag) begin
          exe_d     = 1'b0;
          wcnt_d    = '0;
          retired_d = w_retired_inc;
          if (jmp_flag) begin
            if (w_jump_bad) begin
              state_d = S_ERROR;
              error_d = 1'b1;
            end else begin
              pc_d    = w_jump_target[pc_width-1:0];
              state_d = S_FETCH;
              fcnt_d  = c_release;
            end
          end else if (pc_q == c_pc_max) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            pc_d    = pc_q + pc_width'(1);
            state_d = S_FETCH;
            fcnt_d  = c_release;
          end
        end else if (wcnt_q == c_wcnt_last) begin
          exe_d   = 1'b0;
          state_d = S_ERROR;
          error_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + c_wcnt_w'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_FETCH) || (state_d == S_EXEC);

    // Address is registered from the next pc/fcnt so it is valid for the
    // whole cycle in which that fetch slot is active.
    rom_addr_d = rom_addr_q;
    if ((state_d == S_FETCH) && (fcnt_d <= 3'd3)) begin
      rom_addr_d = address_size'({pc_d, fcnt_d[1:0]});
    end
  end

  // State and registered outputs; synchronous reset aborts any run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fcnt_q      <= 3'd0;
      wcnt_q      <= '0;
      pc_q        <= '0;
      retired_q   <= 16'd0;
      exe_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cmd_flags_q <= 6'd0;
      cmd_args_q  <= '0;
      rom_addr_q  <= '0;
      flags_buf_q <= 6'd0;
      w1_q        <= '0;
      w2_q        <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      wcnt_q      <= wcnt_d;
      pc_q        <= pc_d;
      retired_q   <= retired_d;
      exe_q       <= exe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cmd_flags_q <= cmd_flags_d;
      cmd_args_q  <= cmd_args_d;
      rom_addr_q  <= rom_addr_d;
      flags_buf_q <= flags_buf_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign cmd_flags = cmd_flags_q;
  assign cmd_args  = cmd_args_q;
  assign exe_flag  = exe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign pc        = pc_q;
  assign retired   = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_sequencer
// Description : Self-checking bench for cmd_sequencer: ROM model, executor
//               model on negedge, single-instruction vector table and
//               hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: pc_width = 8 ----------------
  logic        rst = 1'b1, start = 1'b0;
  logic [31:0] rom_addr;
  logic [31:0] rom_data = '0;
  logic [5:0]  cmd_flags;
  logic [95:0] cmd_args;
  logic        exe_flag;
  logic        ready_flag = 1'b0, jmp_flag = 1'b0;
  logic [31:0] offset = '0;
  logic        busy, done, error;
  logic [7:0]  pc;
  logic [15:0] retired;

  cmd_sequencer #(.address_size(32), .word_size(32), .pc_width(8), .timeout(64)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .cmd_flags(cmd_flags), .cmd_args(cmd_args), .exe_flag(exe_flag),
    .ready_flag(ready_flag), .jmp_flag(jmp_flag), .new_exe_addr_offset(offset),
    .busy(busy), .done(done), .error(error), .pc(pc), .retired(retired));

  // ---------------- DUT B: pc_width = 2 ----------------
  logic        rst_b = 1'b1, start_b = 1'b0;
  logic [31:0] rom_addr_b;
  logic [31:0] rom_data_b = '0;
  logic [5:0]  cmd_flags_b;
  logic [95:0] cmd_args_b;
  logic        exe_b;
  logic        ready_b = 1'b0;
  logic        jmp_b = 1'b0;
  logic [31:0] offset_b = '0;
  logic        busy_b, done_b, error_b;
  logic [1:0]  pc_b;
  logic [15:0] retired_b;

  cmd_sequencer #(.address_size(32), .word_size(32), .pc_width(2), .timeout(64)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .cmd_flags(cmd_flags_b), .cmd_args(cmd_args_b), .exe_flag(exe_b),
    .ready_flag(ready_b), .jmp_flag(jmp_b), .new_exe_addr_offset(offset_b),
    .busy(busy_b), .done(done_b), .error(error_b), .pc(pc_b), .retired(retired_b));

  // ROM models, one cycle read latency
  logic [31:0] rom   [0:63];
  logic [31:0] rom_b [0:15];
  always @(posedge clk) rom_data   <= rom[rom_addr[5:0]];
  always @(posedge clk) rom_data_b <= rom_b[rom_addr_b[3:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Executor A + event monitor
  int  ex_delay = 3;
  bit  respond = 1'b1, force_ready = 1'b0;
  int  ecnt = 0, n_rise = 0, n_ready = 0, err_at = -1, start_cyc = 0;
  int  rise_at  [0:15];
  int  ready_at [0:15];
  logic exe_prev = 1'b0, err_prev = 1'b0;

  always @(negedge clk) begin
    if (ready_flag && n_ready < 16) begin ready_at[n_ready] = cyc; n_ready++; end
    if (exe_flag && !exe_prev && n_rise < 16) begin rise_at[n_rise] = cyc; n_rise++; end
    if (error && !err_prev) err_at = cyc;
    exe_prev   = exe_flag;
    err_prev   = error;
    ready_flag = force_ready;
    jmp_flag   = 1'b0;
    if (exe_flag) begin
      ecnt++;
      if (respond && ecnt == ex_delay) begin
        ready_flag = 1'b1;
        jmp_flag   = cmd_flags[2];
        offset     = cmd_args[31:0];
      end
    end else begin
      ecnt = 0;
    end
  end

  // Executor B: always answers on the second exe cycle, never jumps
  int   ecnt_b = 0, n_rise_b = 0;
  logic exe_prev_b = 1'b0;
  always @(negedge clk) begin
    if (exe_b && !exe_prev_b) n_rise_b++;
    exe_prev_b = exe_b;
    ready_b    = 1'b0;
    if (exe_b) begin
      ecnt_b++;
      if (ecnt_b == 2) ready_b = 1'b1;
    end else begin
      ecnt_b = 0;
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
  endtask

  task automatic set_instr(input int p, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    rom[4*p] = w0; rom[4*p+1] = w1; rom[4*p+2] = w2; rom[4*p+3] = w3;
  endtask

  task automatic reset_a();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_rise = 0; n_ready = 0; err_at = -1;
  endtask

  task automatic start_a();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_end(input string nm);
    int i = 0;
    while (!(done || error) && i < 400) begin tick(); i++; end
    chk({nm, "_finished"}, done | error, 1'b1);
  endtask

  task automatic wait_rise(input int n, input string nm);
    int i = 0;
    while (n_rise < n && i < 200) begin tick(); i++; end
    chk({nm, "_rise_seen"}, (n_rise >= n), 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] word0;
    logic [31:0] w1;
    bit          exec;
    bit          dn;
    bit          er;
    logic [15:0] ret;
    logic [7:0]  pcx;
  } vec_t;

  vec_t vecs [0:10];

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // word0, w1, exec, done, error, retired, final pc
    vecs[0]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 16'd0, 8'd0};   // HALT
    vecs[1]  = '{32'h0000_0020, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 16'd1, 8'd1};   // mov
    vecs[2]  = '{32'h0000_0001, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 16'd1, 8'd1};   // ja
    vecs[3]  = '{32'h0000_0003, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 16'd0, 8'd0};   // two flags
    vecs[4]  = '{32'h0000_003F, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 16'd0, 8'd0};   // all flags
    vecs[5]  = '{32'hFFFF_FFC0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 16'd0, 8'd0};   // upper bits ignored
    vecs[6]  = '{32'hABCD_EF08, 32'h0000_0009, 1'b1, 1'b1, 1'b0, 16'd1, 8'd1};   // cmp, junk upper
    vecs[7]  = '{32'h0000_0004, 32'h0000_0100, 1'b1, 1'b0, 1'b1, 16'd1, 8'd0};   // jmp to 256
    vecs[8]  = '{32'h0000_0004, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 16'd1, 8'd1};   // jmp +1
    vecs[9]  = '{32'h0000_0004, 32'h0000_00FF, 1'b1, 1'b1, 1'b0, 16'd1, 8'd255}; // jmp to last pc
    vecs[10] = '{32'h0000_0010, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 16'd1, 8'd1};   // add

    clear_rom();
    for (int i = 0; i < 16; i++) rom_b[i] = 32'h0;
    reset_a();

    // ---- reset state ----
    chk("rst_exe", exe_flag, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_pc", pc, 8'd0);
    chk("rst_retired", retired, 16'd0);
    chk("rst_flags", cmd_flags, 6'd0);
    chk("rst_args", cmd_args, 96'd0);
    chk("rst_addr", rom_addr, 32'd0);

    // ---- table: one instruction at pc 0, HALT everywhere else ----
    for (int v = 0; v < 11; v++) begin
      clear_rom();
      set_instr(0, vecs[v].word0, vecs[v].w1, 32'hA5A5_0000 ^ v, 32'h5A5A_0000 + v);
      ex_delay = 2 + (v % 3);
      respond  = 1'b1;
      reset_a();
      start_a();
      for (int i = 0; i < 20 && n_rise == 0 && !done && !error; i++) tick();
      if (vecs[v].exec) begin
        chk($sformatf("v%0d_flags", v), cmd_flags, vecs[v].word0[5:0]);
        chk($sformatf("v%0d_args", v), cmd_args,
            {32'h5A5A_0000 + v, 32'hA5A5_0000 ^ v, vecs[v].w1});
      end
      wait_end($sformatf("v%0d", v));
      chk($sformatf("v%0d_pulses", v), n_rise, vecs[v].exec ? 1 : 0);
      chk($sformatf("v%0d_done", v), done, vecs[v].dn);
      chk($sformatf("v%0d_error", v), error, vecs[v].er);
      chk($sformatf("v%0d_retired", v), retired, vecs[v].ret);
      chk($sformatf("v%0d_pc", v), pc, vecs[v].pcx);
      chk($sformatf("v%0d_busy", v), busy, 1'b0);
    end

    // ---- T1: MOV, ADD, HALT with latency checks ----
    clear_rom();
    set_instr(0, 32'h20, 32'd1, 32'd5, 32'd0);
    set_instr(1, 32'h10, 32'd2, 32'd1, 32'd1);
    ex_delay = 3; respond = 1'b1;
    reset_a();
    start_a();
    wait_end("t1");
    chk("t1_pulses", n_rise, 2);
    chk("t1_done", done, 1'b1);
    chk("t1_error", error, 1'b0);
    chk("t1_retired", retired, 16'd2);
    chk("t1_pc", pc, 8'd2);
    chk("t1_start_lat", rise_at[0] - start_cyc, 5);
    chk("t1_ready_lat", rise_at[1] - ready_at[0], 6);
    chk("t1_exe_low", exe_flag, 1'b0);

    // ---- T2: JMP +2 skips a bad opcode ----
    clear_rom();
    set_instr(0, 32'h04, 32'd2, 32'd0, 32'd0);
    set_instr(1, 32'h03, 32'd0, 32'd0, 32'd0);
    reset_a();
    start_a();
    wait_end("t2");
    chk("t2_done", done, 1'b1);
    chk("t2_error", error, 1'b0);
    chk("t2_retired", retired, 16'd1);
    chk("t2_pc", pc, 8'd2);

    // ---- T3: executor never answers ----
    clear_rom();
    set_instr(0, 32'h20, 32'd1, 32'd2, 32'd3);
    respond = 1'b0;
    reset_a();
    start_a();
    wait_end("t3");
    chk("t3_error", error, 1'b1);
    chk("t3_done", done, 1'b0);
    chk("t3_timeout", err_at - rise_at[0], 64);
    chk("t3_exe_low", exe_flag, 1'b0);
    chk("t3_retired", retired, 16'd0);
    respond = 1'b1;

    // ---- T4: backward jump below 0, then restart ----
    clear_rom();
    set_instr(0, 32'h04, 32'hFFFF_FFFF, 32'd0, 32'd0);
    reset_a();
    start_a();
    wait_end("t4");
    chk("t4_error", error, 1'b1);
    chk("t4_pc", pc, 8'd0);
    chk("t4_retired", retired, 16'd1);
    start_a();
    chk("t4_restart_error", error, 1'b0);
    chk("t4_restart_busy", busy, 1'b1);
    chk("t4_restart_retired", retired, 16'd0);
    wait_end("t4b");
    chk("t4b_error", error, 1'b1);

    // ---- T5: reset in the second EXEC cycle, late ready ignored ----
    clear_rom();
    set_instr(0, 32'h20, 32'd1, 32'd5, 32'd0);
    set_instr(1, 32'h10, 32'd2, 32'd1, 32'd1);
    ex_delay = 10;
    reset_a();
    start_a();
    wait_rise(2, "t5");
    chk("t5_pc_before", pc, 8'd1);
    chk("t5_ret_before", retired, 16'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_exe", exe_flag, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_pc", pc, 8'd0);
    chk("t5_retired", retired, 16'd0);
    force_ready = 1'b1;
    tick();
    force_ready = 1'b0;
    tick(); tick(); tick();
    chk("t5_late_busy", busy, 1'b0);
    chk("t5_late_retired", retired, 16'd0);
    chk("t5_late_pulses", n_rise, 2);
    ex_delay = 3;

    // ---- T6: pc_width=2, runs off the end, start while busy ignored ----
    rom_b[0]  = 32'h20; rom_b[1]  = 32'h11; rom_b[2]  = 32'h12; rom_b[3]  = 32'h13;
    rom_b[4]  = 32'h10; rom_b[5]  = 32'h21; rom_b[6]  = 32'h22; rom_b[7]  = 32'h23;
    rom_b[8]  = 32'h08; rom_b[9]  = 32'h31; rom_b[10] = 32'h32; rom_b[11] = 32'h33;
    rom_b[12] = 32'h01; rom_b[13] = 32'h41; rom_b[14] = 32'h42; rom_b[15] = 32'h43;
    tick();
    rst_b = 1'b0;
    tick(); start_b = 1'b1;
    tick(); start_b = 1'b0;
    for (int i = 0; i < 20 && n_rise_b < 1; i++) tick();
    chk("t6_flags0", cmd_flags_b, 6'h20);
    chk("t6_args0", cmd_args_b, {32'h13, 32'h12, 32'h11});
    for (int i = 0; i < 100 && n_rise_b < 3; i++) tick();
    chk("t6_third_rise", n_rise_b, 3);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("t6_busy_start_pc", pc_b, 2'd2);
    chk("t6_busy_start_ret", retired_b, 16'd2);
    chk("t6_busy_start_busy", busy_b, 1'b1);
    for (int i = 0; i < 100 && !(done_b || error_b); i++) tick();
    chk("t6_done", done_b, 1'b1);
    chk("t6_error", error_b, 1'b0);
    chk("t6_pc", pc_b, 2'd3);
    chk("t6_retired", retired_b, 16'd4);
    chk("t6_pulses", n_rise_b, 4);
    chk("t6_busy", busy_b, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
